time_keeper: RTL

TIME_KEEPER -- requirements
Module: time_keeper

---
 rtl/time_keeper.sv | 99 +++++++++
 1 files changed

// File: rtl/time_keeper.sv
// Time-of-day keeper: counts prescaled tick_in rising edges into hr:min:sec and
// provides an adjust mode in which minutes and hours are stepped by single pulses.
module time_keeper #(
    parameter int unsigned EDGES_PER_SEC = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       run,
    input  logic       inc_min,
    input  logic       inc_hr,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hr,
    output logic       sec_pulse
);

    localparam logic [15:0] PRE_MAX = 16'(EDGES_PER_SEC - 1);

    logic        tick_q_reg;
    logic        tick_vld_reg;
    logic        tick_vld_next;
    logic [15:0] pre_reg, pre_next;
    logic [5:0]  sec_reg, sec_next;
    logic [5:0]  min_reg, min_next;
    logic [4:0]  hr_reg, hr_next;
    logic        sec_pulse_reg, sec_pulse_next;
    logic        tick_edge;

    // tick_vld_reg keeps a level that was high across reset release from
    // looking like a rising edge: a 0 must have been sampled first.
    assign tick_edge     = tick_in & ~tick_q_reg & tick_vld_reg;
    assign tick_vld_next = 1'b1;

    always_comb begin
        pre_next       = pre_reg;
        sec_next       = sec_reg;
        min_next       = min_reg;
        hr_next        = hr_reg;
        sec_pulse_next = 1'b0;
        if (run) begin
            if (tick_edge) begin
                if (pre_reg == PRE_MAX) begin
                    pre_next       = 16'd0;
                    sec_pulse_next = 1'b1;
                    if (sec_reg == 6'd59) begin
                        sec_next = 6'd0;
                        if (min_reg == 6'd59) begin
                            min_next = 6'd0;
                            hr_next  = (hr_reg == 5'd23) ? 5'd0 : hr_reg + 5'd1;
                        end else begin
                            min_next = min_reg + 6'd1;
                        end
                    end else begin
                        sec_next = sec_reg + 6'd1;
                    end
                end else begin
                    pre_next = pre_reg + 16'd1;
                end
            end
        end else begin
            // Adjust mode: the second is held at zero so that resuming starts a full second.
            pre_next = 16'd0;
            sec_next = 6'd0;
            if (inc_min) begin
                min_next = (min_reg == 6'd59) ? 6'd0 : min_reg + 6'd1;
            end
            if (inc_hr) begin
                hr_next = (hr_reg == 5'd23) ? 5'd0 : hr_reg + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q_reg    <= 1'b0;
            tick_vld_reg  <= 1'b0;
            pre_reg       <= 16'd0;
            sec_reg       <= 6'd0;
            min_reg       <= 6'd0;
            hr_reg        <= 5'd0;
            sec_pulse_reg <= 1'b0;
        end else begin
            tick_q_reg    <= tick_in;
            tick_vld_reg  <= tick_vld_next;
            pre_reg       <= pre_next;
            sec_reg       <= sec_next;
            min_reg       <= min_next;
            hr_reg        <= hr_next;
            sec_pulse_reg <= sec_pulse_next;
        end
    end

    assign sec       = sec_reg;
    assign min       = min_reg;
    assign hr        = hr_reg;
    assign sec_pulse = sec_pulse_reg;

endmodule
